// File: rtl/bus_if_pkg.sv
// Shared encodings for the pipeline-to-memory access initiator: FSM states,
// strobe polarity and read/write direction.
package bus_if_pkg;

  localparam int REGION_W = 3;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  typedef enum logic [1:0] {
    BUS_IF_STATE_IDLE   = 2'h0,
    BUS_IF_STATE_REQ    = 2'h1,
    BUS_IF_STATE_ACCESS = 2'h2,
    BUS_IF_STATE_STALL  = 2'h3
  } bus_if_state_e;

  function automatic logic region_hit(input logic [REGION_W-1:0] region,
                                      input logic [REGION_W-1:0] sel);
    return (region == sel);
  endfunction

endpackage

// File: rtl/bus_if.sv
// Per-stage memory access initiator: zero-wait scratch-pad port or a
// request/grant/strobe/ready transaction on the shared external bus.
module bus_if
  import bus_if_pkg::*;
#(
  parameter int                  ADDR_W     = 30,
  parameter int                  SPM_ADDR_W = 12,
  parameter logic [REGION_W-1:0] SPM_REGION = 3'b011
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  as_,
  input  logic                  rw,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data,
  output logic                  busy,
  output logic [SPM_ADDR_W-1:0] spm_addr,
  output logic                  spm_as_,
  output logic                  spm_rw,
  output logic [31:0]           spm_wr_data,
  input  logic [31:0]           spm_rd_data,
  output logic                  bus_req_,
  input  logic                  bus_grnt_,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic                  bus_as_,
  output logic                  bus_rw,
  output logic [31:0]           bus_wr_data,
  input  logic [31:0]           bus_rd_data,
  input  logic                  bus_rdy_
);

  bus_if_state_e     state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_as_q, bus_as_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              bus_rw_q, bus_rw_d;
  logic [31:0]       bus_wr_data_q, bus_wr_data_d;
  logic [31:0]       rd_buf_q, rd_buf_d;

  logic spm_hit_s;
  logic req_s;

  assign spm_hit_s = region_hit(addr[ADDR_W-1:ADDR_W-REGION_W], SPM_REGION);
  assign req_s     = (as_ == ENABLE_) && !flush;

  assign bus_req_    = bus_req_q;
  assign bus_as_     = bus_as_q;
  assign bus_addr    = bus_addr_q;
  assign bus_rw      = bus_rw_q;
  assign bus_wr_data = bus_wr_data_q;

  // Next-state, bus register updates and combinational stage/scratch-pad outputs.
  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_as_d      = bus_as_q;
    bus_addr_d    = bus_addr_q;
    bus_rw_d      = bus_rw_q;
    bus_wr_data_d = bus_wr_data_q;
    rd_buf_d      = rd_buf_q;
    rd_data       = rd_buf_q;
    busy          = 1'b0;
    spm_as_       = DISABLE_;
    spm_addr      = addr[SPM_ADDR_W-1:0];
    spm_rw        = rw;
    spm_wr_data   = wr_data;

    case (state_q)
      BUS_IF_STATE_IDLE: begin
        if (spm_hit_s) begin
          rd_data = spm_rd_data;
          if (req_s) begin
            spm_as_ = ENABLE_;
          end else begin
            spm_as_ = DISABLE_;
          end
        end else if (req_s) begin
          bus_addr_d    = addr;
          bus_rw_d      = rw;
          bus_wr_data_d = wr_data;
          bus_req_d     = ENABLE_;
          busy          = 1'b1;
          state_d       = BUS_IF_STATE_REQ;
        end else begin
          state_d = BUS_IF_STATE_IDLE;
        end
      end
      BUS_IF_STATE_REQ: begin
        busy = 1'b1;
        if (bus_grnt_ == ENABLE_) begin
          bus_as_d = ENABLE_;
          state_d  = BUS_IF_STATE_ACCESS;
        end else begin
          state_d = BUS_IF_STATE_REQ;
        end
      end
      BUS_IF_STATE_ACCESS: begin
        // Strobe is a single-cycle pulse regardless of how long ready takes.
        bus_as_d = DISABLE_;
        busy     = (bus_rdy_ != ENABLE_);
        if (bus_rdy_ == ENABLE_) begin
          rd_data   = bus_rd_data;
          bus_req_d = DISABLE_;
          if (bus_rw_q == READ) begin
            rd_buf_d = bus_rd_data;
          end else begin
            rd_buf_d = rd_buf_q;
          end
          if (stall) begin
            state_d = BUS_IF_STATE_STALL;
          end else begin
            state_d = BUS_IF_STATE_IDLE;
          end
        end else begin
          state_d = BUS_IF_STATE_ACCESS;
        end
      end
      BUS_IF_STATE_STALL: begin
        // Completed data is held here so the stalled stage still sees it.
        if (!stall) begin
          state_d = BUS_IF_STATE_IDLE;
        end else begin
          state_d = BUS_IF_STATE_STALL;
        end
      end
      default: begin
        state_d = BUS_IF_STATE_IDLE;
      end
    endcase
  end

  // State and bus master register bank.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q       <= BUS_IF_STATE_IDLE;
      bus_req_q     <= DISABLE_;
      bus_as_q      <= DISABLE_;
      bus_addr_q    <= {ADDR_W{1'b0}};
      bus_rw_q      <= READ;
      bus_wr_data_q <= 32'h0000_0000;
      rd_buf_q      <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_as_q      <= bus_as_d;
      bus_addr_q    <= bus_addr_d;
      bus_rw_q      <= bus_rw_d;
      bus_wr_data_q <= bus_wr_data_d;
      rd_buf_q      <= rd_buf_d;
    end
  end

endmodule

// File: tb/tb_bus_if.sv
// Scoreboard bench for bus_if: stimulus queues expected bus/read responses,
// a negedge monitor pops and compares them whenever the DUT completes an access.
module tb_bus_if;
  import bus_if_pkg::*;

  logic        clk = 1'b0;
  logic        reset_;
  logic        stall, flush, as_, rw;
  logic [29:0] addr;
  logic [31:0] wr_data, rd_data, spm_wr_data, spm_rd_data, bus_wr_data, bus_rd_data;
  logic        busy, spm_as_, spm_rw, bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
  logic [11:0] spm_addr;
  logic [29:0] bus_addr;

  always #5 clk = ~clk;

  bus_if #(.ADDR_W(30), .SPM_ADDR_W(12), .SPM_REGION(3'b011)) dut (
    .clk(clk), .reset_(reset_), .stall(stall), .flush(flush), .addr(addr),
    .as_(as_), .rw(rw), .wr_data(wr_data), .rd_data(rd_data), .busy(busy),
    .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
    .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr),
    .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [29:0] a;
    logic        r;
    logic [31:0] d;
  } bus_exp_t;

  bus_exp_t    exp_bus_q[$];
  logic [31:0] exp_rd_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT output with no expected entry queued", name);
  endtask

  // Monitor: compare every access completion the DUT presents against the queues.
  always @(negedge clk) begin
    logic [31:0] e;
    bus_exp_t    b;
    if (reset_) begin
      if (spm_as_ == 1'b0) begin
        if (exp_rd_q.size() == 0) unexpected("spm_access");
        else begin
          e = exp_rd_q.pop_front();
          check("spm_rd_data", rd_data, e);
        end
      end
      if (bus_as_ == 1'b0) begin
        if (exp_bus_q.size() == 0) unexpected("bus_strobe");
        else begin
          b = exp_bus_q.pop_front();
          check("bus_addr", {2'b00, bus_addr}, {2'b00, b.a});
          check("bus_rw", {31'd0, bus_rw}, {31'd0, b.r});
          check("bus_wr_data", bus_wr_data, b.d);
        end
      end
      if (bus_req_ == 1'b0 && bus_rdy_ == 1'b0 && busy == 1'b0) begin
        if (exp_rd_q.size() == 0) unexpected("bus_ready");
        else begin
          e = exp_rd_q.pop_front();
          check("bus_rd_data", rd_data, e);
        end
      end
    end
  end

  // One bus transaction; the bench acts as arbiter and slave with the given delays.
  task automatic bus_txn(input logic [29:0] a, input logic r, input logic [31:0] wd,
                         input logic [31:0] rdv, input int gdly, input int rdly,
                         input int stall_n, input logic flush_mid,
                         output int busy_n, output int req_n, output int as_n);
    int   req_wait = 0, acc_wait = 0, post = 0;
    logic in_acc = 1'b0, done = 1'b0, finished = 1'b0, gnt_now, rdy_now;
    busy_n = 0; req_n = 0; as_n = 0;
    exp_bus_q.push_back({a, r, wd});
    exp_rd_q.push_back(rdv);
    addr = a; rw = r; wr_data = wd; as_ = 1'b0; bus_rd_data = rdv;
    for (int i = 0; i < 60; i++) begin
      gnt_now = 1'b0; rdy_now = 1'b0;
      if (i > 0) begin
        as_ = 1'b1;
        if (flush_mid) flush = 1'b1;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
        if (done) begin
          post++;
          stall = (post <= stall_n) ? 1'b1 : 1'b0;
          bus_rd_data = 32'h5A5A_5A5A;
        end else if (in_acc) begin
          if (acc_wait == rdly) begin
            bus_rdy_ = 1'b0; rdy_now = 1'b1;
            stall = (stall_n > 0) ? 1'b1 : 1'b0;
          end
          acc_wait++;
        end else if (bus_req_ == 1'b0) begin
          if (req_wait == gdly) begin
            bus_grnt_ = 1'b0; gnt_now = 1'b1;
          end
          req_wait++;
        end
      end
      @(negedge clk);
      if (busy) busy_n++;
      if (!bus_req_) req_n++;
      if (!bus_as_) as_n++;
      if (done && r == READ) check("held_rd_data", rd_data, rdv);
      if (done) check("post_busy", {31'd0, busy}, 32'd0);
      if (done && post >= stall_n + 1) begin
        finished = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (gnt_now) in_acc = 1'b1;
      if (rdy_now) begin in_acc = 1'b0; done = 1'b1; end
    end
    if (!finished) unexpected("txn_timeout");
    @(posedge clk); #1;
    stall = 1'b0; flush = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
  endtask

  initial begin
    int bn, rn, an;
    reset_ = 1'b1; stall = 1'b0; flush = 1'b0; as_ = 1'b1; rw = READ;
    addr = 30'h0; wr_data = 32'h0; spm_rd_data = 32'h0; bus_rd_data = 32'h0;
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    #2 reset_ = 1'b0;
    #1;
    check("rst_bus_req_", {31'd0, bus_req_}, 32'd1);
    check("rst_bus_as_", {31'd0, bus_as_}, 32'd1);
    check("rst_bus_addr", {2'b00, bus_addr}, 32'd0);
    check("rst_bus_rw", {31'd0, bus_rw}, 32'd1);
    check("rst_bus_wr_data", bus_wr_data, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 reset_ = 1'b1;

    // Scratch-pad read then write, zero wait.
    @(posedge clk); #1;
    addr = 30'h1800_0004; rw = READ; as_ = 1'b0; spm_rd_data = 32'hDEAD_BEEF;
    exp_rd_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    check("spm_addr_rd", {20'd0, spm_addr}, 32'h0000_0004);
    check("spm_busy", {31'd0, busy}, 32'd0);
    check("spm_rw_rd", {31'd0, spm_rw}, 32'd1);
    @(posedge clk); #1;
    check("spm_no_bus_req", {31'd0, bus_req_}, 32'd1);
    addr = 30'h1800_0ABC; rw = WRITE; wr_data = 32'hA5A5_0F0F;
    exp_rd_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    check("spm_addr_wr", {20'd0, spm_addr}, 32'h0000_0ABC);
    check("spm_rw_wr", {31'd0, spm_rw}, 32'd0);
    check("spm_wr_data", spm_wr_data, 32'hA5A5_0F0F);
    @(posedge clk); #1 as_ = 1'b1;

    // Bus write: granted in the second REQ cycle, ready in the first ACCESS cycle.
    bus_txn(30'h0000_0010, WRITE, 32'h1234_5678, 32'h0BAD_F00D, 1, 0, 0, 1'b0, bn, rn, an);
    check("wr_busy_cycles", bn, 32'd3);
    check("wr_req_cycles", rn, 32'd3);
    check("wr_as_cycles", an, 32'd1);

    // Bus read with ready and stall together, stall held three more cycles.
    bus_txn(30'h0000_0020, READ, 32'h0, 32'hCAFE_0001, 0, 0, 3, 1'b0, bn, rn, an);
    check("stall_busy_cycles", bn, 32'd2);
    check("stall_req_cycles", rn, 32'd2);
    check("stall_as_cycles", an, 32'd1);

    // Flush raised during the transaction does not cut it short.
    bus_txn(30'h0000_0030, READ, 32'h0, 32'h0F0F_1234, 0, 2, 0, 1'b1, bn, rn, an);
    check("flush_busy_cycles", bn, 32'd4);
    check("flush_req_cycles", rn, 32'd4);
    check("flush_as_cycles", an, 32'd1);

    // Flush in IDLE suppresses both bus and scratch-pad accesses.
    addr = 30'h0000_0100; as_ = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("flush_idle_busy", {31'd0, busy}, 32'd0);
    check("flush_idle_spm_as_", {31'd0, spm_as_}, 32'd1);
    @(posedge clk); #1;
    check("flush_idle_bus_req_", {31'd0, bus_req_}, 32'd1);
    addr = 30'h1800_0008;
    @(negedge clk);
    check("flush_spm_as_", {31'd0, spm_as_}, 32'd1);
    @(posedge clk); #1 as_ = 1'b1; flush = 1'b0;

    // Reset while in ACCESS drops the master outputs immediately.
    addr = 30'h0000_0040; rw = READ; wr_data = 32'h7777_0000; as_ = 1'b0;
    exp_bus_q.push_back({30'h0000_0040, READ, 32'h7777_0000});
    @(posedge clk); #1 as_ = 1'b1; bus_grnt_ = 1'b0;
    @(posedge clk); #1 bus_grnt_ = 1'b1;
    check("pre_rst_bus_as_", {31'd0, bus_as_}, 32'd0);
    @(negedge clk);
    #2 reset_ = 1'b0;
    #1;
    check("midrst_bus_req_", {31'd0, bus_req_}, 32'd1);
    check("midrst_bus_as_", {31'd0, bus_as_}, 32'd1);
    @(posedge clk); #1 reset_ = 1'b1;
    @(negedge clk);
    check("post_rst_rd_data", rd_data, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_bus_req_", {31'd0, bus_req_}, 32'd1);

    @(posedge clk); #1;
    check("rd_queue_drained", exp_rd_q.size(), 32'd0);
    check("bus_queue_drained", exp_bus_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
